// File: rtl/quant_pkg.sv
// rtl/quant_pkg.sv - shared types and constants for the fp32 quantizer
package quant_pkg;

    localparam int FP32_BIAS = 127;
    localparam int Q_MAX     = 255;
    localparam int Q_MIN     = 0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    // Denormals fold into zero: only the exponent field decides "zero".
    function automatic fp_class_t fp_classify(input fp32_t v);
        fp_class_t c;
        c = FP_NORM;
        if (v.exp == 8'd0) begin
            c = FP_ZERO;
        end else if (v.exp == 8'hff) begin
            c = (v.man == 23'd0) ? FP_INF : FP_NAN;
        end
        return c;
    endfunction

endpackage

// File: rtl/quant_round_sat.sv
// rtl/quant_round_sat.sv - align product to integer, round half-even, add zero point, clamp
module quant_round_sat
    import quant_pkg::*;
#(
    parameter int ZERO_POINT = 0
) (
    input  fp_class_t          cls,
    input  logic               sign,
    input  logic [47:0]        prod,
    input  logic signed [9:0]  esum,
    output logic [7:0]         q,
    output logic               sat
);
    localparam logic signed [11:0] ZP = 12'(ZERO_POINT);

    logic signed [10:0] e_u;
    logic signed [10:0] e_n;
    logic [3:0]         k;
    logic [57:0]        w;
    logic [8:0]         int_part;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic [9:0]         mag;
    logic [9:0]         mag_eff;
    logic signed [11:0] sum;

    // Product value is prod * 2^(e_u-46); shifting left by e_u+3 puts the
    // binary point between bits 49 and 48 so the integer, guard and sticky
    // fields sit at fixed positions. Only used for normalized exponents -1..8.
    always_comb begin
        e_u      = {esum[9], esum} - 11'(FP32_BIAS);
        e_n      = e_u + {10'd0, prod[47]};
        k        = 4'(e_u + 11'sd3);
        w        = {10'd0, prod} << k;
        int_part = w[57:49];
        guard    = w[48];
        sticky   = |w[47:0];
        round_up = guard & (sticky | int_part[0]);
        mag      = {1'b0, int_part} + {9'd0, round_up};
        mag_eff  = (e_n <= -11'sd2) ? 10'd0 : mag;
        sum      = sign ? (ZP - $signed({2'b00, mag_eff}))
                        : (ZP + $signed({2'b00, mag_eff}));
        q        = 8'(ZERO_POINT);
        sat      = 1'b0;
        case (cls)
            FP_NAN: begin
                q   = 8'(ZERO_POINT);
                sat = 1'b1;
            end
            FP_INF: begin
                q   = sign ? 8'(Q_MIN) : 8'(Q_MAX);
                sat = 1'b1;
            end
            FP_NORM: begin
                if (e_n >= 11'sd9) begin
                    q   = sign ? 8'(Q_MIN) : 8'(Q_MAX);
                    sat = 1'b1;
                end else if (sum < 12'sd0) begin
                    q   = 8'(Q_MIN);
                    sat = 1'b1;
                end else if (sum > $signed(12'(Q_MAX))) begin
                    q   = 8'(Q_MAX);
                    sat = 1'b1;
                end else begin
                    q   = sum[7:0];
                    sat = 1'b0;
                end
            end
            default: begin
                q   = 8'(ZERO_POINT);
                sat = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/quant_pipe.sv
// rtl/quant_pipe.sv - 3-stage fp32 x fp32 to uint8 quantizer with valid/ready flow control
module quant_pipe
    import quant_pkg::*;
#(
    parameter int ZERO_POINT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_fp,
    input  logic [31:0] scale_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_q,
    output logic        out_sat
);
    fp32_t              a;
    fp32_t              b;
    fp_class_t          cls_a;
    fp_class_t          cls_b;
    fp_class_t          cls_in;

    logic               v1;
    logic               v2;

    fp_class_t          s1_cls;
    logic               s1_sign;
    logic [23:0]        s1_ma;
    logic [23:0]        s1_mb;
    logic [7:0]         s1_ea;
    logic [7:0]         s1_eb;

    fp_class_t          s2_cls;
    logic               s2_sign;
    logic [47:0]        s2_prod;
    logic signed [9:0]  s2_esum;

    logic [7:0]         q_next;
    logic               sat_next;

    assign a        = fp32_t'(in_fp);
    assign b        = fp32_t'(scale_inv);
    // Whole pipe moves as one; bubbles travel with it.
    assign in_ready = !out_valid || out_ready;

    // Combine operand classes; Inf x 0 behaves like NaN.
    always_comb begin
        cls_a  = fp_classify(a);
        cls_b  = fp_classify(b);
        cls_in = FP_NORM;
        if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            cls_in = FP_NAN;
        end else if ((cls_a == FP_INF && cls_b == FP_ZERO) ||
                     (cls_a == FP_ZERO && cls_b == FP_INF)) begin
            cls_in = FP_NAN;
        end else if (cls_a == FP_INF || cls_b == FP_INF) begin
            cls_in = FP_INF;
        end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
            cls_in = FP_ZERO;
        end
    end

    // Valid chain and output registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= 8'd0;
            out_sat   <= 1'b0;
        end else if (in_ready) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            out_q     <= q_next;
            out_sat   <= sat_next;
        end
    end

    // Unreset datapath: S1 unpack/classify, S2 mantissa multiply and exponent sum.
    always_ff @(posedge clk) begin
        if (in_ready) begin
            s1_cls  <= cls_in;
            s1_sign <= a.sign ^ b.sign;
            s1_ma   <= {1'b1, a.man};
            s1_mb   <= {1'b1, b.man};
            s1_ea   <= a.exp;
            s1_eb   <= b.exp;
            s2_cls  <= s1_cls;
            s2_sign <= s1_sign;
            s2_prod <= 48'(s1_ma) * 48'(s1_mb);
            s2_esum <= 10'({2'b00, s1_ea}) + 10'({2'b00, s1_eb}) - 10'(FP32_BIAS);
        end
    end

    quant_round_sat #(
        .ZERO_POINT (ZERO_POINT)
    ) u_round_sat (
        .cls  (s2_cls),
        .sign (s2_sign),
        .prod (s2_prod),
        .esum (s2_esum),
        .q    (q_next),
        .sat  (sat_next)
    );

endmodule

// File: tb/tb_quant_pipe.sv
// tb/tb_quant_pipe.sv - directed self-checking bench for quant_pipe
module tb_quant_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_fp;
    logic [31:0] scale_inv;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_sat0;
    logic [7:0]  out_q0;
    logic        in_ready1, out_valid1, out_sat1;
    logic [7:0]  out_q1;

    int total = 0;
    int bad   = 0;

    logic [31:0] vals [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    always #5 clk = ~clk;

    quant_pipe #(.ZERO_POINT(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_fp     (in_fp),
        .scale_inv (scale_inv),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_q     (out_q0),
        .out_sat   (out_sat0)
    );

    quant_pipe #(.ZERO_POINT(128)) dut128 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_fp     (in_fp),
        .scale_inv (scale_inv),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_q     (out_q1),
        .out_sat   (out_sat1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int q0, input int s0, input int q1, input int s1);
        int lat;
        @(negedge clk);
        in_fp     = a;
        scale_inv = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},   lat, 3);
        chk({tag, "_q0"},    out_q0, q0);
        chk({tag, "_sat0"},  out_sat0, s0);
        chk({tag, "_v128"},  out_valid1, 1);
        chk({tag, "_q128"},  out_q1, q1);
        chk({tag, "_sat128"}, out_sat1, s1);
    endtask

    initial begin
        int idx;
        int n_out;
        int stall_left;
        bit first_seen;
        int held_q;
        bit stray;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fp     = 32'd0;
        scale_inv = 32'h3F800000;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_q",     out_q0, 0);
        chk("rst_out_sat",   out_sat0, 0);
        chk("rst_in_ready",  in_ready0, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_in_ready", in_ready0, 1);

        run_one("basic3",   32'h40400000, 32'h3F800000,   3, 0, 131, 0);
        run_one("tie2p5",   32'h40200000, 32'h3F800000,   2, 0, 130, 0);
        run_one("tie3p5",   32'h40600000, 32'h3F800000,   4, 0, 132, 0);
        run_one("tie0p5",   32'h3F000000, 32'h3F800000,   0, 0, 128, 0);
        run_one("tie1p5x2", 32'h3FC00000, 32'h40000000,   3, 0, 131, 0);
        run_one("r0p75",    32'h3F400000, 32'h3F800000,   1, 0, 129, 0);
        run_one("small",    32'h3E800000, 32'h3F800000,   0, 0, 128, 0);
        run_one("tie127p5", 32'h42FF0000, 32'h3F800000, 128, 0, 255, 1);
        run_one("sat300",   32'h43960000, 32'h3F800000, 255, 1, 255, 1);
        run_one("neg1",     32'hBF800000, 32'h3F800000,   0, 1, 127, 0);
        run_one("neg2p5",   32'hC0200000, 32'h3F800000,   0, 1, 126, 0);
        run_one("edge255",  32'h437F0000, 32'h3F800000, 255, 0, 255, 1);
        run_one("bigneg",   32'h447A0000, 32'hBF800000,   0, 1,   0, 1);
        run_one("nan",      32'h7FC00000, 32'h3F800000,   0, 1, 128, 1);
        run_one("inf",      32'h7F800000, 32'h3F800000, 255, 1, 255, 1);
        run_one("infx0",    32'h7F800000, 32'h00000000,   0, 1, 128, 1);
        run_one("denorm",   32'h00000001, 32'h3F800000,   0, 0, 128, 0);

        idx        = 0;
        n_out      = 0;
        stall_left = 0;
        first_seen = 1'b0;
        held_q     = 0;
        scale_inv  = 32'h3F800000;
        for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
            @(negedge clk);
            if (out_valid0 && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 5;
                held_q     = out_q0;
            end
            out_ready = !(first_seen && stall_left > 0);
            in_valid  = (idx < 8);
            in_fp     = (idx < 8) ? vals[idx] : 32'd0;
            #1;
            if (first_seen && stall_left > 0) begin
                chk("bp_in_ready_low", in_ready0, 0);
                chk("bp_valid_held",   out_valid0, 1);
                chk("bp_q_held",       out_q0, held_q);
                stall_left--;
            end
            if (out_valid0 && out_ready) begin
                chk("bp_order", out_q0, n_out + 1);
                chk("bp_sat",   out_sat0, 0);
                n_out++;
            end
            if (in_valid && in_ready0) idx++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", n_out, 8);
        chk("bp_first_q", held_q, 1);
        repeat (4) @(negedge clk);

        in_valid  = 1'b1;
        in_fp     = 32'h40A00000;
        @(negedge clk);
        in_fp     = 32'h40C00000;
        @(negedge clk);
        in_fp     = 32'h40E00000;
        @(negedge clk);
        in_valid  = 1'b0;
        chk("rst_pre_valid", out_valid0, 1);
        chk("rst_pre_q",     out_q0, 5);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid",    out_valid0, 0);
        chk("rst_mid_q",        out_q0, 0);
        chk("rst_mid_in_ready", in_ready0, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) stray = 1'b1;
        end
        chk("rst_no_stale", stray, 0);
        run_one("after_rst", 32'h40400000, 32'h3F800000, 3, 0, 131, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
